// File: rtl/conv_pkg.sv
// Shared state encoding and default geometry for the convolution weight store.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  localparam int CONV_NUM_K  = 32;
  localparam int CONV_KH     = 11;
  localparam int CONV_KW     = 7;
  localparam int CONV_DATA_W = 8;

endpackage

// File: rtl/conv_wbuf_row_mux.sv
// Combinational pick of one kernel row across every kernel; zero latency, no flow control.
// Out-of-range selects (only possible when 2^RW > KH) return zero.
module conv_wbuf_row_mux
  import conv_pkg::*;
#(
  parameter int NUM_K  = CONV_NUM_K,
  parameter int KH     = CONV_KH,
  parameter int KW     = CONV_KW,
  parameter int DATA_W = CONV_DATA_W,
  parameter int RW     = 4
) (
  input  logic [KW*DATA_W-1:0]       rows    [NUM_K][KH],
  input  logic [RW-1:0]              sel,
  output logic [NUM_K*KW*DATA_W-1:0] row_out
);

  localparam int ROW_W = KW * DATA_W;

  always_comb begin
    row_out = '0;
    for (int n = 0; n < NUM_K; n++) begin
      if (int'(sel) < KH) begin
        row_out[n*ROW_W +: ROW_W] = rows[n][sel];
      end
    end
  end

endmodule

// File: rtl/conv_weight_store.sv
// NUM_K x KH x KW weight store: kernel-major load over valid/ready, one row of all kernels per rd_en (1-cycle latency, no output backpressure).
// Optional load checksum built only when CONV_WBUF_CHECKSUM_EN is defined.
module conv_weight_store
  import conv_pkg::*;
#(
  parameter int NUM_K  = CONV_NUM_K,
  parameter int KH     = CONV_KH,
  parameter int KW     = CONV_KW,
  parameter int DATA_W = CONV_DATA_W,
  parameter int RW     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_start,
  input  logic                        wr_valid,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ready,
  output logic                        load_done,
  input  logic                        stage_start,
  input  logic [RW-1:0]               row_lo,
  input  logic [RW-1:0]               row_hi,
  input  logic                        rd_en,
  output logic                        out_valid,
  output logic [RW-1:0]               out_row,
  output logic [NUM_K*KW*DATA_W-1:0]  out_weight,
  output logic [15:0]                 checksum
);

  localparam int ROW_W = KW * DATA_W;
  localparam int OUT_W = NUM_K * ROW_W;
  localparam int KIW   = (NUM_K > 1) ? $clog2(NUM_K) : 1;
  localparam int CW    = (KW > 1) ? $clog2(KW) : 1;

  localparam logic [RW-1:0]  ROW_MAX = RW'(KH - 1);
  localparam logic [KIW-1:0] K_LAST  = KIW'(NUM_K - 1);
  localparam logic [CW-1:0]  C_LAST  = CW'(KW - 1);

  state_e          state_q, state_d;
  logic [KIW-1:0]  k_q, k_d;
  logic [RW-1:0]   r_q, r_d;
  logic [CW-1:0]   c_q, c_d;
  logic [RW-1:0]   lo_q, lo_d, hi_q, hi_d, ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [RW-1:0]   out_row_q, out_row_d;
  logic [OUT_W-1:0] out_weight_q, out_weight_d;
  logic [ROW_W-1:0] mem_q [NUM_K][KH];
  logic [ROW_W-1:0] mem_d [NUM_K][KH];

  logic            wr_fire, rd_fire;
  logic [RW-1:0]   lo_stg, hi_stg, lo_eff, hi_eff, ptr_eff;
  logic [OUT_W-1:0] row_sel;

  assign wr_ready  = (state_q == ST_LOAD);
  assign load_done = (state_q == ST_READY);
  assign wr_fire   = wr_ready && wr_valid && !load_start;
  assign rd_fire   = load_done && rd_en && !load_start;

  // Load sequencing: column, then row, then kernel counters walk the element order.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    c_d     = c_q;
    mem_d   = mem_q;
    if (load_start) begin
      state_d = ST_LOAD;
      k_d     = '0;
      r_d     = '0;
      c_d     = '0;
    end else if (wr_fire) begin
      mem_d[k_q][r_q][c_q*DATA_W +: DATA_W] = wr_data;
      if (c_q == C_LAST) begin
        c_d = '0;
        if (r_q == ROW_MAX) begin
          r_d = '0;
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = ST_READY;
          end else begin
            k_d = k_q + 1'b1;
          end
        end else begin
          r_d = r_q + 1'b1;
        end
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // A stage_start in the same cycle as rd_en must steer that read, so the
  // window and pointer are bypassed from the inputs rather than the flops.
  always_comb begin
    lo_stg = (row_lo > ROW_MAX) ? ROW_MAX : row_lo;
    if (row_hi < lo_stg) begin
      hi_stg = lo_stg;
    end else if (row_hi > ROW_MAX) begin
      hi_stg = ROW_MAX;
    end else begin
      hi_stg = row_hi;
    end
    lo_eff  = stage_start ? lo_stg : lo_q;
    hi_eff  = stage_start ? hi_stg : hi_q;
    ptr_eff = stage_start ? lo_stg : ptr_q;
  end

  conv_wbuf_row_mux #(
    .NUM_K  (NUM_K),
    .KH     (KH),
    .KW     (KW),
    .DATA_W (DATA_W),
    .RW     (RW)
  ) u_row_mux (
    .rows    (mem_q),
    .sel     (ptr_eff),
    .row_out (row_sel)
  );

  always_comb begin
    lo_d         = lo_eff;
    hi_d         = hi_eff;
    ptr_d        = ptr_eff;
    out_valid_d  = rd_fire;
    out_row_d    = out_row_q;
    out_weight_d = out_weight_q;
    if (rd_fire) begin
      out_row_d    = ptr_eff;
      out_weight_d = row_sel;
      ptr_d        = (ptr_eff == hi_eff) ? lo_eff : ptr_eff + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      r_q          <= '0;
      c_q          <= '0;
      lo_q         <= '0;
      hi_q         <= ROW_MAX;
      ptr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_weight_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      r_q          <= r_d;
      c_q          <= c_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_row_q    <= out_row_d;
      out_weight_q <= out_weight_d;
    end
  end

  // Weight storage carries no reset; a reload always rewrites every entry.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid  = out_valid_q;
  assign out_row    = out_row_q;
  assign out_weight = out_weight_q;

`ifdef CONV_WBUF_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (load_start) begin
      csum_d = '0;
    end else if (wr_fire) begin
      csum_d = csum_q + 16'(wr_data);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule
